// File: rtl/op_executor.sv
// op_executor
//   Executes the op sequence issued by the state transition handler against a
//   Horner polynomial evaluator. The result of each op is reported back as an
//   op_change pulse, with success valid in that cycle. A watchdog expiry or a
//   host halt ends the op with an abort pulse instead.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   op              current op code (INIT/RUN/RESULT/DONE/CLRERR/APPLY/RERUN)
//   degree, x_in    polynomial degree and evaluation point, latched by INIT
//   expected        reference value for RESULT, latched when RESULT is decoded
//   halt            host abort request
//   coef_addr       coefficient RAM address; coef_data returns one cycle later
//   op_change       1-cycle pulse when the current op has finished
//   success         outcome of the last finished op, held until the next one
//   abort           1-cycle pulse on watchdog expiry or halt
//   result          published accumulator value (APPLY); result_vld flags it
//   err             sticky arithmetic overflow flag
//   done            high while parked on a DONE op
module op_executor #(
  parameter int DATA_W  = 16,
  parameter int MAX_DEG = 7,
  parameter int TIMEOUT = 255,
  parameter int AW      = $clog2(MAX_DEG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [2:0]        degree,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] expected,
  input  logic              halt,
  output logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              op_change,
  output logic              success,
  output logic              abort,
  output logic [DATA_W-1:0] result,
  output logic              result_vld,
  output logic              err,
  output logic              done
);

  localparam int PW  = 2 * DATA_W;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(32'd1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [2:0] OP_INIT   = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_RESULT = 3'd2;
  localparam logic [2:0] OP_DONE   = 3'd3;
  localparam logic [2:0] OP_CLRERR = 3'd4;
  localparam logic [2:0] OP_APPLY  = 3'd5;
  localparam logic [2:0] OP_RERUN  = 3'd6;
  localparam logic [2:0] OP_UNDEF  = 3'd7;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_DECODE = 3'd1,
    ST_EVAL   = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t                   state_r;
  logic [2:0]               op_q_r;
  logic signed [DATA_W-1:0] acc_r;
  logic signed [DATA_W-1:0] x_r;
  logic [2:0]               deg_r;
  logic [3:0]               cnt_r;
  logic [WDW-1:0]           wd_r;
  logic [DATA_W-1:0]        exp_r;
  logic                     run_ovf_r;

  logic signed [PW-1:0]     prod_s;
  logic [DATA_W:0]          sum_s;
  logic                     step_ovf_s;
  logic                     stop_s;
  logic [3:0]               last_s;

  // True when a full-width product is representable in signed DATA_W bits.
  function automatic logic fits_signed(input logic [PW-1:0] p);
    return (&p[PW-1:DATA_W-1]) | ~(|p[PW-1:DATA_W-1]);
  endfunction

  // One Horner step: full-width product, truncate, add coefficient, flag overflow.
  always_comb begin
    prod_s     = PW'(acc_r) * PW'(x_r);
    sum_s      = {prod_s[DATA_W-1], prod_s[DATA_W-1:0]} + {coef_data[DATA_W-1], coef_data};
    step_ovf_s = !fits_signed(prod_s) || (sum_s[DATA_W] != sum_s[DATA_W-1]);
    stop_s     = halt || (wd_r == WD_LAST);
    last_s     = {1'b0, deg_r} + 4'd1;
  end

  // Op sequencing FSM with evaluator datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_SETTLE;
      op_q_r     <= OP_INIT;
      acc_r      <= '0;
      x_r        <= '0;
      deg_r      <= 3'd0;
      cnt_r      <= 4'd0;
      wd_r       <= '0;
      exp_r      <= '0;
      run_ovf_r  <= 1'b0;
      coef_addr  <= '0;
      op_change  <= 1'b0;
      success    <= 1'b0;
      abort      <= 1'b0;
      result     <= '0;
      result_vld <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      op_change <= 1'b0;
      abort     <= 1'b0;
      case (state_r)
        ST_SETTLE: state_r <= ST_DECODE;

        ST_DECODE: begin
          op_q_r <= op;
          // The decode cycle itself is the first cycle the watchdog charges.
          wd_r   <= WD_ONE;
          if (op == OP_DONE || op == OP_UNDEF) begin
            // Park here, re-sampling op every cycle; halt is ignored while idle.
            done    <= 1'b1;
            state_r <= ST_DECODE;
          end else if (halt) begin
            done    <= 1'b0;
            abort   <= 1'b1;
            acc_r   <= '0;
            state_r <= ST_SETTLE;
          end else begin
            done <= 1'b0;
            case (op)
              OP_INIT: begin
                x_r        <= x_in;
                deg_r      <= degree;
                acc_r      <= '0;
                err        <= 1'b0;
                result_vld <= 1'b0;
                success    <= 1'b1;
                op_change  <= 1'b1;
                state_r    <= ST_REPORT;
              end
              OP_RUN, OP_RERUN: begin
                acc_r     <= '0;
                cnt_r     <= 4'd0;
                run_ovf_r <= 1'b0;
                coef_addr <= AW'(deg_r);
                state_r   <= ST_EVAL;
              end
              OP_RESULT, OP_APPLY, OP_CLRERR: begin
                exp_r   <= expected;
                state_r <= ST_EXEC1;
              end
              default: state_r <= ST_DECODE;
            endcase
          end
        end

        ST_EVAL: begin
          if (stop_s) begin
            abort     <= 1'b1;
            acc_r     <= '0;
            coef_addr <= '0;
            state_r   <= ST_SETTLE;
          end else begin
            wd_r  <= wd_r + WD_ONE;
            cnt_r <= cnt_r + 4'd1;
            // Address runs one cycle ahead of the data it selects.
            if (cnt_r < {1'b0, deg_r}) begin
              coef_addr <= AW'({1'b0, deg_r} - cnt_r - 4'd1);
            end
            // Cycle 0 only primes the RAM; data for c[N] arrives in cycle 1.
            if (cnt_r != 4'd0) begin
              acc_r <= sum_s[DATA_W-1:0];
              if (step_ovf_s) begin
                run_ovf_r <= 1'b1;
                err       <= 1'b1;
              end
            end
            if (cnt_r == last_s) begin
              success   <= !(run_ovf_r || step_ovf_s);
              op_change <= 1'b1;
              state_r   <= ST_REPORT;
            end
          end
        end

        ST_EXEC1: begin
          if (stop_s) begin
            abort   <= 1'b1;
            acc_r   <= '0;
            state_r <= ST_SETTLE;
          end else begin
            case (op_q_r)
              OP_RESULT: success <= ($unsigned(acc_r) == exp_r);
              OP_APPLY: begin
                result     <= acc_r;
                result_vld <= 1'b1;
                success    <= !err;
              end
              OP_CLRERR: begin
                err     <= 1'b0;
                success <= 1'b1;
              end
              default: success <= 1'b0;
            endcase
            op_change <= 1'b1;
            state_r   <= ST_REPORT;
          end
        end

        ST_REPORT: state_r <= ST_SETTLE;

        default: state_r <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_executor.sv
// tb_op_executor
//   Directed and randomized stimulus for op_executor. The bench plays the
//   transition handler (issues ops, advances on op_change/abort), models the
//   coefficient RAM, and predicts every outcome from an arithmetic reference.
module tb_op_executor;

  localparam int DW = 16;
  localparam int TO = 10;

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] RESULT = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] CLRERR = 3'd4;
  localparam logic [2:0] APPLY  = 3'd5;
  localparam logic [2:0] RERUN  = 3'd6;

  logic          clk;
  logic          rst;
  logic [2:0]    op;
  logic [2:0]    degree;
  logic [DW-1:0] x_in;
  logic [DW-1:0] expected;
  logic          halt;
  logic [2:0]    coef_addr;
  logic [DW-1:0] coef_data;
  logic          op_change;
  logic          success;
  logic          abort;
  logic [DW-1:0] result;
  logic          result_vld;
  logic          err;
  logic          done;

  op_executor #(.DATA_W(DW), .MAX_DEG(7), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .degree(degree), .x_in(x_in),
    .expected(expected), .halt(halt), .coef_addr(coef_addr),
    .coef_data(coef_data), .op_change(op_change), .success(success),
    .abort(abort), .result(result), .result_vld(result_vld), .err(err),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read coefficient RAM: data for an address appears next cycle.
  logic signed [DW-1:0] ram [0:7];
  always @(posedge clk) coef_data <= ram[coef_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  longint      m_x, m_acc;
  int          m_n;
  bit          m_err, m_vld, m_succ;
  logic [15:0] m_res;
  int          offset;  // cycles already spent toward the next op's decode

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint w16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
  endfunction

  // Evaluate sum c[i]*x^i by Horner with 16-bit wrap, noting any overflow.
  task automatic model_horner(output bit ovf);
    longint a, p, s;
    a = 0;
    ovf = 1'b0;
    for (int i = m_n; i >= 0; i--) begin
      p = a * m_x;
      if (p > 32767 || p < -32768) ovf = 1'b1;
      p = w16(p);
      s = p + longint'(ram[i]);
      if (s > 32767 || s < -32768) ovf = 1'b1;
      a = w16(s);
    end
    m_acc = a;
  endtask

  task automatic do_op(input logic [2:0] o, input string tag);
    int lat, exp_lat;
    bit chg, ab, exp_ab, ovf;
    exp_ab = 1'b0;
    case (o)
      INIT:       exp_lat = 3;
      RUN, RERUN: begin
        exp_lat = m_n + 5;
        // decode cycle plus N+2 evaluation cycles charged to the watchdog
        exp_ab  = (m_n + 3 >= TO);
      end
      default:    exp_lat = 4;
    endcase
    if (exp_ab) exp_lat = TO + 2;
    exp_lat = exp_lat - offset;
    op = o;
    lat = 0; chg = 1'b0; ab = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (op_change || abort) begin
        lat = i; chg = op_change; ab = abort;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_abort"}, {31'd0, ab}, {31'd0, exp_ab});
    chk({tag, "_chg"}, {31'd0, chg}, {31'd0, !exp_ab});
    if (exp_ab) begin
      m_acc = 0;
      offset = 1;
    end else begin
      offset = 0;
      case (o)
        INIT: begin
          m_x = longint'($signed(x_in)); m_n = int'(degree);
          m_acc = 0; m_err = 1'b0; m_vld = 1'b0; m_succ = 1'b1;
        end
        RUN, RERUN: begin
          model_horner(ovf);
          if (ovf) m_err = 1'b1;
          m_succ = !ovf;
        end
        RESULT: m_succ = (w16(m_acc) == longint'($signed(expected)));
        APPLY: begin
          m_res = m_acc[15:0]; m_vld = 1'b1; m_succ = !m_err;
        end
        CLRERR: begin
          m_err = 1'b0; m_succ = 1'b1;
        end
        default: ;
      endcase
    end
    chk({tag, "_success"}, {31'd0, success}, {31'd0, m_succ});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, "_vld"}, {31'd0, result_vld}, {31'd0, m_vld});
    chk({tag, "_result"}, {16'd0, result}, {16'd0, m_res});
  endtask

  function automatic logic [15:0] small_val(input int range);
    int v;
    v = int'($urandom_range(0, 2 * range)) - range;
    return v[15:0];
  endfunction

  initial begin
    int bad;
    rst = 1'b1; op = INIT; degree = 3'd0; x_in = '0; expected = '0; halt = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = '0;
    m_x = 0; m_acc = 0; m_n = 0; m_err = 0; m_vld = 0; m_succ = 0; m_res = '0;
    offset = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {7'd0, op_change, success, abort, result, result_vld, err, done, coef_addr}, 32'd0);
    rst = 1'b0;

    // Worked example: N=2, x=3, c2..c0 = 1,2,3 -> 18
    degree = 3'd2; x_in = 16'd3; ram[2] = 16'sd1; ram[1] = 16'sd2; ram[0] = 16'sd3;
    do_op(INIT, "t1_init");
    do_op(RUN, "t1_run");
    expected = 16'd18; do_op(RESULT, "t2_eq");
    chk("t2_eq_true", {31'd0, success}, 32'd1);
    expected = 16'd17; do_op(RESULT, "t2_ne");
    chk("t2_ne_false", {31'd0, success}, 32'd0);
    do_op(APPLY, "t4_apply");
    chk("t4_result18", {16'd0, result}, 32'd18);

    // Overflow: x=300, c1=300, c0=0 -> 300*300 does not fit
    degree = 3'd1; x_in = 16'd300; ram[1] = 16'sd300; ram[0] = 16'sd0;
    do_op(INIT, "t3_init");
    chk("t4_vld_cleared", {31'd0, result_vld}, 32'd0);
    do_op(RUN, "t3_run");
    chk("t3_err_set", {31'd0, err}, 32'd1);
    do_op(CLRERR, "t3_clrerr");
    chk("t3_err_clear", {31'd0, err}, 32'd0);

    // Randomized op sequences, alternating small and full-range operands
    for (int it = 0; it < 8; it++) begin
      degree = 3'($urandom_range(0, 6));
      if (it % 2 == 0) begin
        x_in = small_val(20);
        for (int i = 0; i < 8; i++) ram[i] = small_val(200);
      end else begin
        x_in = 16'($urandom);
        for (int i = 0; i < 8; i++) ram[i] = 16'($urandom);
      end
      do_op(INIT, "r_init");
      do_op(RUN, "r_run");
      expected = ($urandom_range(0, 1) == 0) ? m_acc[15:0] : (m_acc[15:0] ^ 16'h0001);
      do_op(RESULT, "r_result");
      do_op(APPLY, "r_apply");
      if (m_err) do_op(CLRERR, "r_clrerr");
      do_op(RERUN, "r_rerun");
      expected = ($urandom_range(0, 1) == 0) ? m_acc[15:0] : (m_acc[15:0] ^ 16'h0100);
      do_op(RESULT, "r_result2");
    end

    // Watchdog: degree 7 needs more cycles than the budget allows
    degree = 3'd7; x_in = 16'd1;
    for (int i = 0; i < 8; i++) ram[i] = 16'sd1;
    do_op(INIT, "t5_init");
    do_op(RUN, "t5_timeout");
    expected = 16'd0; do_op(RESULT, "t5_acc_cleared");

    // Halt in the middle of evaluation
    degree = 3'd4;
    do_op(INIT, "t5h_init");
    op = RUN; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (op_change || abort) bad++;
    end
    chk("halt_pre_quiet", bad, 0);
    halt = 1'b1;
    @(negedge clk);
    chk("halt_abort", {31'd0, abort}, 32'd1);
    chk("halt_no_chg", {31'd0, op_change}, 32'd0);
    halt = 1'b0; m_acc = 0; offset = 1;
    expected = 16'd0; do_op(RESULT, "halt_acc_cleared");

    // Asynchronous reset in the middle of a run with a result already published
    degree = 3'd6;
    do_op(INIT, "t6_init");
    do_op(RUN, "t6_run");
    do_op(APPLY, "t6_apply");
    op = RERUN;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", {7'd0, op_change, success, abort, result, result_vld, err, done, coef_addr}, 32'd0);
    @(negedge clk);
    op = DONE; rst = 1'b0;
    m_x = 0; m_acc = 0; m_n = 0; m_err = 0; m_vld = 0; m_succ = 0; m_res = '0;

    // DONE parks: done stays high and nothing is reported
    repeat (3) @(negedge clk);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!done || op_change || abort) bad++;
    end
    chk("t6_done_park", bad, 0);
    offset = 2;
    degree = 3'd0; x_in = 16'd5; ram[0] = -16'sd7;
    do_op(INIT, "t6_leave_done");
    chk("t6_done_low", {31'd0, done}, 32'd0);
    do_op(RUN, "t6_deg0");
    expected = 16'hFFF9; do_op(RESULT, "t6_deg0_val");
    chk("t6_deg0_true", {31'd0, success}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
